// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the JTAG master: controller state encoding,
// per-state TMS levels and the TCK cycle overheads of each command type.
package jtag_master_pkg;

    typedef enum logic [3:0] {
        ST_TLR,
        ST_ENTER_RTI,
        ST_IDLE,
        ST_NULL,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_TO_SHIFT,
        ST_SHIFT,
        ST_UPDATE,
        ST_TO_IDLE
    } state_t;

    localparam int TLR_CYCLES = 5;

    localparam logic TMS_TLR        = 1'b1;
    localparam logic TMS_ENTER_RTI  = 1'b0;
    localparam logic TMS_IDLE       = 1'b0;
    localparam logic TMS_SEL_DR     = 1'b1;
    localparam logic TMS_SEL_IR     = 1'b1;
    localparam logic TMS_CAPTURE    = 1'b0;
    localparam logic TMS_TO_SHIFT   = 1'b0;
    localparam logic TMS_SHIFT      = 1'b0;
    localparam logic TMS_SHIFT_LAST = 1'b1;
    localparam logic TMS_UPDATE     = 1'b1;
    localparam logic TMS_TO_IDLE    = 1'b0;

    // TCK cycles spent outside the shift phase of each command type
    localparam int DR_OVERHEAD  = 5;
    localparam int IR_OVERHEAD  = 6;
    localparam int RESET_CYCLES = TLR_CYCLES + 1;

    function automatic logic tck_running(input state_t s);
        return !(s == ST_IDLE || s == ST_NULL);
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every CLK_DIV clk cycles while enabled, parks low
// otherwise; strobes flag the clk edges that drive tck high and low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap     = en && (div_cnt == DIV_LAST);
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG driver: turns IR/DR scan and TAP-reset commands into TCK/TMS/TDI
// sequences, one controller state per TCK cycle, and returns captured TDO bits.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_reset,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               trst_n
);

    state_t             state;
    logic [2:0]         tlr_cnt;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_c;
    logic [MAX_LEN-1:0] sr;
    logic               ir_q;
    logic               reset_q;
    logic               active_q;
    logic               accept;
    logic               to_idle;
    logic               rise_stb;
    logic               fall_stb;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (tck_running(state)),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign len_c   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign accept  = cmd_valid && cmd_ready;
    assign to_idle = (state == ST_NULL) ||
                     (fall_stb && (state == ST_ENTER_RTI || state == ST_TO_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) trst_n <= 1'b0;
        else     trst_n <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_TLR;
            tlr_cnt   <= 3'(TLR_CYCLES);
            bit_cnt   <= '0;
            len_q     <= '0;
            sr        <= '0;
            ir_q      <= 1'b0;
            reset_q   <= 1'b0;
            active_q  <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;

            if (state == ST_IDLE && accept) begin
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                active_q  <= 1'b1;
                reset_q   <= cmd_reset;
                ir_q      <= cmd_ir;
                len_q     <= len_c;
                bit_cnt   <= len_c;
                sr        <= cmd_data;
                if (cmd_reset) begin
                    state   <= ST_TLR;
                    tlr_cnt <= 3'(TLR_CYCLES);
                    tms     <= TMS_TLR;
                end else if (len_c == '0) begin
                    state <= ST_NULL;
                end else begin
                    state <= ST_SEL_DR;
                    tms   <= TMS_SEL_DR;
                end
            end

            // TDO is stable here: the target launched it on the previous TCK fall
            if (rise_stb && state == ST_SHIFT)
                sr <= {tdo, sr[MAX_LEN-1:1]};

            if (fall_stb) begin
                case (state)
                    ST_TLR: begin
                        if (tlr_cnt == 3'd1) begin
                            state <= ST_ENTER_RTI;
                            tms   <= TMS_ENTER_RTI;
                        end else begin
                            tlr_cnt <= tlr_cnt - 3'd1;
                        end
                    end
                    ST_SEL_DR: begin
                        if (ir_q) begin
                            state <= ST_SEL_IR;
                            tms   <= TMS_SEL_IR;
                        end else begin
                            state <= ST_CAPTURE;
                            tms   <= TMS_CAPTURE;
                        end
                    end
                    ST_SEL_IR: begin
                        state <= ST_CAPTURE;
                        tms   <= TMS_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        state <= ST_TO_SHIFT;
                        tms   <= TMS_TO_SHIFT;
                    end
                    ST_TO_SHIFT: begin
                        state <= ST_SHIFT;
                        tms   <= (bit_cnt == LEN_W'(1)) ? TMS_SHIFT_LAST : TMS_SHIFT;
                        tdi   <= sr[0];
                    end
                    ST_SHIFT: begin
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == LEN_W'(1)) begin
                            state <= ST_UPDATE;
                            tms   <= TMS_UPDATE;
                            tdi   <= 1'b0;
                        end else begin
                            tms <= (bit_cnt == LEN_W'(2)) ? TMS_SHIFT_LAST : TMS_SHIFT;
                            tdi <= sr[0];
                        end
                    end
                    ST_UPDATE: begin
                        state <= ST_TO_IDLE;
                        tms   <= TMS_TO_IDLE;
                    end
                    default: ;
                endcase
            end

            // Captured bits sit in the top len_q positions of sr
            if (to_idle) begin
                state     <= ST_IDLE;
                tms       <= TMS_IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                active_q  <= 1'b0;
                rsp_valid <= active_q;
                if (active_q)
                    rsp_data <= reset_q ? '0 : (sr >> (LEN_W'(MAX_LEN) - len_q));
            end
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: drives commands into a behavioural TAP target and checks
// responses, TCK counts and TMS sequences against expectations derived from JTAG rules.
module tb_jtag_master;
    import jtag_master_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam logic [31:0] IDCODE     = 32'h12345157;
    localparam logic [3:0]  IR_IDCODE  = 4'h1;
    localparam logic [3:0]  IR_USER    = 4'h8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_reset = 1'b0, cmd_ir = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic cmd_ready, rsp_valid, busy, tck, tms, tdi, trst_n;
    logic [MAX_LEN-1:0] rsp_data;
    logic tdo_m = 1'b0;

    always #5 clk = ~clk;

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms),
        .tdi(tdi), .tdo(tdo_m), .trst_n(trst_n)
    );

    // Behavioural TAP target: IDCODE, 32-bit user register, bypass
    typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHD, T_E1D, T_PD, T_E2D, T_UDR,
                      T_SIR, T_CIR, T_SHI, T_E1I, T_PI, T_E2I, T_UIR} tap_t;
    tap_t ts = T_TLR;
    logic [3:0]  ir = IR_IDCODE, ir_sr = 4'h0;
    logic [31:0] dr_id = '0, dr_user = '0, user_in = '0, user_out = '0;
    logic        dr_byp = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR: return m ? T_TLR : T_RTI;
            T_RTI: return m ? T_SDR : T_RTI;
            T_SDR: return m ? T_SIR : T_CDR;
            T_CDR: return m ? T_E1D : T_SHD;
            T_SHD: return m ? T_E1D : T_SHD;
            T_E1D: return m ? T_UDR : T_PD;
            T_PD:  return m ? T_E2D : T_PD;
            T_E2D: return m ? T_UDR : T_SHD;
            T_UDR: return m ? T_SDR : T_RTI;
            T_SIR: return m ? T_TLR : T_CIR;
            T_CIR: return m ? T_E1I : T_SHI;
            T_SHI: return m ? T_E1I : T_SHI;
            T_E1I: return m ? T_UIR : T_PI;
            T_PI:  return m ? T_E2I : T_PI;
            T_E2I: return m ? T_UIR : T_SHI;
            T_UIR: return m ? T_SDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ts = T_TLR;
            ir = IR_IDCODE;
        end else begin
            case (ts)
                T_TLR: ir = IR_IDCODE;
                T_CDR: begin
                    if (ir == IR_IDCODE)    dr_id = IDCODE;
                    else if (ir == IR_USER) dr_user = user_in;
                    else                    dr_byp = 1'b0;
                end
                T_SHD: begin
                    if (ir == IR_IDCODE)    dr_id = {tdi, dr_id[31:1]};
                    else if (ir == IR_USER) dr_user = {tdi, dr_user[31:1]};
                    else                    dr_byp = tdi;
                end
                T_UDR: if (ir == IR_USER) user_out = dr_user;
                T_CIR: ir_sr = 4'b0001;
                T_SHI: ir_sr = {tdi, ir_sr[3:1]};
                T_UIR: ir = ir_sr;
                default: ;
            endcase
            ts = tap_next(ts, tms);
        end
    end

    always @(negedge tck or negedge trst_n) begin
        if (!trst_n)           tdo_m = 1'b0;
        else if (ts == T_SHD)  tdo_m = (ir == IR_IDCODE) ? dr_id[0] :
                                       (ir == IR_USER) ? dr_user[0] : dr_byp;
        else if (ts == T_SHI)  tdo_m = ir_sr[0];
        else                   tdo_m = 1'b0;
    end

    // Activity monitor, sampled just after each clk edge
    int tck_rises = 0, rv_cnt = 0;
    logic [63:0] tms_hist = '0;
    logic [31:0] last_rsp = '0;
    logic tck_q = 1'b0;
    always @(posedge clk) begin
        #1;
        if (tck && !tck_q) begin
            tck_rises++;
            tms_hist = {tms_hist[62:0], tms};
        end
        tck_q = tck;
        if (rsp_valid) begin
            rv_cnt++;
            last_rsp = rsp_data;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lmask(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] exp_tms(input bit is_ir, input int len);
        logic [63:0] h;
        h = {63'd0, 1'b1};
        if (is_ir) h = {h[62:0], 1'b1};
        h = {h[61:0], 2'b00};
        for (int k = 0; k < len; k++) h = {h[62:0], (k == len - 1)};
        h = {h[61:0], 2'b10};
        return h;
    endfunction

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!cmd_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk({tag, "_ready_timeout"}, cmd_ready, 1);
    endtask

    // Issues one command and checks TCK count, TMS sequence and single rsp pulse
    task automatic run_cmd(input string tag, input bit is_reset, input bit is_ir, input int len,
                           input logic [31:0] data, output logic [31:0] rsp,
                           output int nbusy, output int lat);
        int lc, exp_tck;
        lc = (len > MAX_LEN) ? MAX_LEN : len;
        exp_tck = is_reset ? RESET_CYCLES : (lc == 0) ? 0 :
                  lc + (is_ir ? IR_OVERHEAD : DR_OVERHEAD);
        wait_ready(tag);
        cmd_reset = is_reset;
        cmd_ir    = is_ir;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        tck_rises = 0;
        rv_cnt    = 0;
        tms_hist  = '0;
        nbusy     = 0;
        lat       = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (busy) nbusy++;
        end while (rv_cnt == 0 && lat < 5000);
        if (rv_cnt == 0) chk({tag, "_rsp_timeout"}, rv_cnt, 1);
        repeat (3) @(negedge clk);
        rsp = last_rsp;
        chk({tag, "_tck_cycles"}, tck_rises, exp_tck);
        chk({tag, "_rsp_pulses"}, rv_cnt, 1);
        if (is_reset)     chk({tag, "_tms"}, tms_hist & lmask(6), 64'b111110);
        else if (lc != 0) chk({tag, "_tms"}, tms_hist & lmask(exp_tck), exp_tms(is_ir, lc));
    endtask

    initial begin
        logic [31:0] rsp, data, uin;
        int nbusy, lat, len, guard;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_trst_n", trst_n, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 1);

        tck_rises = 0;
        tms_hist  = '0;
        rv_cnt    = 0;
        rst = 1'b0;
        @(posedge clk);
        #1 chk("trst_n_release", trst_n, 1);
        wait_ready("powerup");
        chk("powerup_tck_cycles", tck_rises, 6);
        chk("powerup_tms", tms_hist & lmask(6), 64'b111110);
        chk("powerup_busy", busy, 0);
        chk("powerup_no_rsp", rv_cnt, 0);

        run_cmd("idcode", 0, 0, 32, 32'h0, rsp, nbusy, lat);
        chk("idcode_rsp", rsp, IDCODE);
        chk("idcode_busy_clks", (nbusy >= 37*2*CLK_DIV - 2) && (nbusy <= 37*2*CLK_DIV + 2), 1);

        run_cmd("ir_user", 0, 1, 4, 32'h8, rsp, nbusy, lat);
        chk("ir_user_rsp", rsp, 32'h1);

        user_in = 32'hCAFEF00D;
        run_cmd("user32", 0, 0, 32, 32'hDEADBEEF, rsp, nbusy, lat);
        chk("user32_rsp", rsp, 32'hCAFEF00D);
        chk("user32_out", user_out, 32'hDEADBEEF);

        for (int i = 0; i < 5; i++) begin
            len  = $urandom_range(32, 1);
            data = $urandom;
            uin  = $urandom;
            user_in = uin;
            run_cmd("user_rand", 0, 0, len, data, rsp, nbusy, lat);
            chk("user_rand_rsp", rsp, 64'(uin) & lmask(len));
            chk("user_rand_out", user_out,
                ((64'(uin) >> len) | ((64'(data) & lmask(len)) << (32 - len))) & lmask(32));
        end

        run_cmd("ir_bypass", 0, 1, 4, 32'hF, rsp, nbusy, lat);
        chk("ir_bypass_rsp", rsp, 32'h1);
        run_cmd("bypass8", 0, 0, 8, 32'hA5, rsp, nbusy, lat);
        chk("bypass8_rsp", rsp, 32'h4A);

        for (int i = 0; i < 4; i++) begin
            len  = $urandom_range(32, 1);
            data = $urandom;
            run_cmd("bypass_rand", 0, 0, len, data, rsp, nbusy, lat);
            chk("bypass_rand_rsp", rsp, (64'(data) << 1) & lmask(len));
        end

        run_cmd("len0", 0, 0, 0, 32'hFFFF_FFFF, rsp, nbusy, lat);
        chk("len0_rsp", rsp, 0);
        chk("len0_latency", lat, 2);

        data = $urandom;
        run_cmd("len40", 0, 0, 40, data, rsp, nbusy, lat);
        chk("len40_rsp", rsp, (64'(data) << 1) & lmask(32));

        run_cmd("tap_reset", 1, 0, 0, 32'h0, rsp, nbusy, lat);
        chk("tap_reset_rsp", rsp, 0);
        run_cmd("idcode_after_reset", 0, 0, 32, 32'h0, rsp, nbusy, lat);
        chk("idcode_after_reset_rsp", rsp, IDCODE);

        wait_ready("midrst");
        cmd_reset = 1'b0;
        cmd_ir    = 1'b0;
        cmd_len   = LEN_W'(32);
        cmd_data  = '0;
        cmd_valid = 1'b1;
        tck_rises = 0;
        rv_cnt    = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (tck_rises < 14 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_reached_bit10", tck_rises, 14);
        chk("midrst_ready_low", cmd_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_tck", tck, 0);
        chk("midrst_tms", tms, 1);
        chk("midrst_trst_n", trst_n, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_rsp_data", rsp_data, 0);
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", rv_cnt, 0);
        tck_rises = 0;
        tms_hist  = '0;
        rst = 1'b0;
        wait_ready("midrst_release");
        chk("midrst_tlr_cycles", tck_rises, 6);
        chk("midrst_tlr_tms", tms_hist & lmask(6), 64'b111110);
        chk("midrst_no_rsp_after", rv_cnt, 0);
        run_cmd("idcode_after_rst", 0, 0, 32, 32'h0, rsp, nbusy, lat);
        chk("idcode_after_rst_rsp", rsp, IDCODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
